// File: rtl/pcie_tlp_tx.sv
// Transmit-side MRd/MWr TLP builder for the 64-bit AXI-stream PCIe TX interface.
// Define TLP_TX_STATS_EN to add the stat_tlp_cnt / stat_dw_cnt counters.
module pcie_tlp_tx #(
   parameter int C_DATA_WIDTH   = 64,
   parameter int KEEP_WIDTH     = C_DATA_WIDTH/8,
   parameter int MAX_PAYLOAD_DW = 128
) (
   input  logic                    user_clk,
   input  logic                    user_reset_n,
   input  logic [7:0]              cfg_bus_number,
   input  logic [4:0]              cfg_device_number,
   input  logic [2:0]              cfg_function_number,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_is_write,
   input  logic [63:0]             cmd_addr,
   input  logic [9:0]              cmd_len_dw,
   input  logic [7:0]              cmd_tag,
   input  logic [3:0]              cmd_first_be,
   input  logic [3:0]              cmd_last_be,
   input  logic [63:0]             wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic                    cmd_err,
   output logic                    s_axis_tx_req,
   input  logic                    s_axis_tx_ack,
   input  logic                    s_axis_tx_tready,
   output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
   output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
   output logic [3:0]              s_axis_tx_tuser,
   output logic                    s_axis_tx_tlast,
   output logic                    s_axis_tx_tvalid
`ifdef TLP_TX_STATS_EN
   ,
   output logic [31:0]             stat_tlp_cnt,
   output logic [31:0]             stat_dw_cnt
`endif
);

   localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD_DW);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR0, S_HDR1, S_DATA} state_t;
   state_t state;

   logic        is_wr, is_4dw, fin;
   logic [61:0] addr_q;
   logic [9:0]  len_q;
   logic [7:0]  tag_q;
   logic [3:0]  fbe_q, lbe_q;
   logic [10:0] rem;
   logic [31:0] held;

   logic [10:0] cmd_len_eff, len_eff_q;
   logic        cmd_drop, cmd_fire, tx_fire, can_load, need_wr, wr_fire;
   logic [31:0] h0, h1, addr_lo, addr_hi;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^cmd_addr[1:0];
   assign s_axis_tx_tuser  = 4'b0;

   assign cmd_len_eff = (cmd_len_dw == 10'd0) ? 11'd1024 : {1'b0, cmd_len_dw};
   assign len_eff_q   = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
   assign cmd_drop    = cmd_is_write && (cmd_len_eff > MAX_LEN);
   assign cmd_fire    = cmd_valid && cmd_ready;
   assign tx_fire     = s_axis_tx_tvalid && s_axis_tx_tready;
   // The output register may take a new beat when empty or being drained.
   assign can_load    = !s_axis_tx_tvalid || s_axis_tx_tready;

   assign h0      = {1'b0, is_wr, is_4dw, 5'b0, 8'h00, 6'b0, len_q};
   assign h1      = {cfg_bus_number, cfg_device_number, cfg_function_number, tag_q,
                     (len_q == 10'd1) ? 4'h0 : lbe_q, fbe_q};
   assign addr_lo = {addr_q[29:0], 2'b00};
   assign addr_hi = addr_q[61:30];

   always_comb begin
      need_wr = 1'b0;
      if (!fin) begin
         case (state)
            S_HDR1:  need_wr = is_wr && !is_4dw;
            S_DATA:  need_wr = is_4dw || (rem != 11'd1);
            default: need_wr = 1'b0;
         endcase
      end
   end

   assign wr_ready = need_wr && s_axis_tx_tready;
   assign wr_fire  = wr_valid && wr_ready;

   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state            <= S_IDLE;
         cmd_ready        <= 1'b0;
         cmd_err          <= 1'b0;
         s_axis_tx_req    <= 1'b0;
         s_axis_tx_tvalid <= 1'b0;
         s_axis_tx_tdata  <= '0;
         s_axis_tx_tkeep  <= '0;
         s_axis_tx_tlast  <= 1'b0;
         is_wr            <= 1'b0;
         is_4dw           <= 1'b0;
         addr_q           <= '0;
         len_q            <= '0;
         tag_q            <= '0;
         fbe_q            <= '0;
         lbe_q            <= '0;
         rem              <= '0;
         held             <= '0;
         fin              <= 1'b0;
      end else begin
         cmd_err <= 1'b0;
         if (tx_fire) s_axis_tx_tvalid <= 1'b0;
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_fire) begin
                  if (cmd_drop) begin
                     cmd_err <= 1'b1;
                  end else begin
                     is_wr         <= cmd_is_write;
                     is_4dw        <= (cmd_addr[63:32] != 32'd0);
                     addr_q        <= cmd_addr[63:2];
                     len_q         <= cmd_len_dw;
                     tag_q         <= cmd_tag;
                     fbe_q         <= cmd_first_be;
                     lbe_q         <= cmd_last_be;
                     cmd_ready     <= 1'b0;
                     s_axis_tx_req <= 1'b1;
                     state         <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (s_axis_tx_ack) state <= S_HDR0;
            end
            S_HDR0: begin
               if (can_load) begin
                  s_axis_tx_tvalid <= 1'b1;
                  s_axis_tx_tdata  <= {h1, h0};
                  s_axis_tx_tkeep  <= 8'hFF;
                  s_axis_tx_tlast  <= 1'b0;
                  state            <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (!fin && can_load) begin
                  if (is_4dw) begin
                     s_axis_tx_tvalid <= 1'b1;
                     s_axis_tx_tdata  <= {addr_lo, addr_hi};
                     s_axis_tx_tkeep  <= 8'hFF;
                     if (!is_wr) begin
                        s_axis_tx_tlast <= 1'b1;
                        fin             <= 1'b1;
                     end else begin
                        rem   <= len_eff_q;
                        state <= S_DATA;
                     end
                  end else if (!is_wr) begin
                     s_axis_tx_tvalid <= 1'b1;
                     s_axis_tx_tdata  <= {32'b0, addr_lo};
                     s_axis_tx_tkeep  <= 8'h0F;
                     s_axis_tx_tlast  <= 1'b1;
                     fin              <= 1'b1;
                  end else if (wr_fire) begin
                     // 3DW write: D0 rides beside H2, D1 waits in the skid register.
                     s_axis_tx_tvalid <= 1'b1;
                     s_axis_tx_tdata  <= {wr_data[31:0], addr_lo};
                     s_axis_tx_tkeep  <= 8'hFF;
                     held             <= wr_data[63:32];
                     if (len_eff_q == 11'd1) begin
                        s_axis_tx_tlast <= 1'b1;
                        fin             <= 1'b1;
                     end else begin
                        rem   <= len_eff_q - 11'd1;
                        state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (!fin && can_load) begin
                  if (is_4dw) begin
                     if (wr_fire) begin
                        s_axis_tx_tvalid <= 1'b1;
                        s_axis_tx_tdata  <= wr_data;
                        s_axis_tx_tkeep  <= (rem == 11'd1) ? 8'h0F : 8'hFF;
                        if (rem <= 11'd2) begin
                           s_axis_tx_tlast <= 1'b1;
                           fin             <= 1'b1;
                        end else begin
                           rem <= rem - 11'd2;
                        end
                     end
                  end else if (rem == 11'd1) begin
                     s_axis_tx_tvalid <= 1'b1;
                     s_axis_tx_tdata  <= {32'b0, held};
                     s_axis_tx_tkeep  <= 8'h0F;
                     s_axis_tx_tlast  <= 1'b1;
                     fin              <= 1'b1;
                  end else if (wr_fire) begin
                     s_axis_tx_tvalid <= 1'b1;
                     s_axis_tx_tdata  <= {wr_data[31:0], held};
                     s_axis_tx_tkeep  <= 8'hFF;
                     held             <= wr_data[63:32];
                     if (rem == 11'd2) begin
                        s_axis_tx_tlast <= 1'b1;
                        fin             <= 1'b1;
                     end else begin
                        rem <= rem - 11'd2;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
         // Link is released only once the tlast beat has actually been taken.
         if (fin && tx_fire) begin
            state           <= S_IDLE;
            fin             <= 1'b0;
            s_axis_tx_tlast <= 1'b0;
            s_axis_tx_req   <= 1'b0;
            cmd_ready       <= 1'b1;
         end
      end
   end

`ifdef TLP_TX_STATS_EN
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         stat_tlp_cnt <= '0;
         stat_dw_cnt  <= '0;
      end else if (fin && tx_fire) begin
         stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
         stat_dw_cnt  <= stat_dw_cnt + (is_wr ? 32'(len_eff_q) : 32'd0);
      end
   end
`endif

endmodule

// File: tb/tb_pcie_tlp_tx.sv
// Directed bench for pcie_tlp_tx: hand-computed TLP beats checked against an expected-beat queue.
module tb_pcie_tlp_tx;

   logic        user_clk = 1'b0;
   logic        user_reset_n;
   logic [7:0]  cfg_bus_number;
   logic [4:0]  cfg_device_number;
   logic [2:0]  cfg_function_number;
   logic        cmd_valid, cmd_ready, cmd_is_write;
   logic [63:0] cmd_addr;
   logic [9:0]  cmd_len_dw;
   logic [7:0]  cmd_tag;
   logic [3:0]  cmd_first_be, cmd_last_be;
   logic [63:0] wr_data;
   logic        wr_valid, wr_ready, cmd_err;
   logic        s_axis_tx_req, s_axis_tx_ack, s_axis_tx_tready;
   logic [63:0] s_axis_tx_tdata;
   logic [7:0]  s_axis_tx_tkeep;
   logic [3:0]  s_axis_tx_tuser;
   logic        s_axis_tx_tlast, s_axis_tx_tvalid;
`ifdef TLP_TX_STATS_EN
   logic [31:0] stat_tlp_cnt, stat_dw_cnt;
`endif

   pcie_tlp_tx dut (
      .user_clk(user_clk), .user_reset_n(user_reset_n),
      .cfg_bus_number(cfg_bus_number), .cfg_device_number(cfg_device_number),
      .cfg_function_number(cfg_function_number),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
      .cmd_addr(cmd_addr), .cmd_len_dw(cmd_len_dw), .cmd_tag(cmd_tag),
      .cmd_first_be(cmd_first_be), .cmd_last_be(cmd_last_be),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .cmd_err(cmd_err),
      .s_axis_tx_req(s_axis_tx_req), .s_axis_tx_ack(s_axis_tx_ack),
      .s_axis_tx_tready(s_axis_tx_tready), .s_axis_tx_tdata(s_axis_tx_tdata),
      .s_axis_tx_tkeep(s_axis_tx_tkeep), .s_axis_tx_tuser(s_axis_tx_tuser),
      .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid)
`ifdef TLP_TX_STATS_EN
      , .stat_tlp_cnt(stat_tlp_cnt), .stat_dw_cnt(stat_dw_cnt)
`endif
   );

   // clock / reset
   always #5 user_clk = ~user_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // checking
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // scoreboard: {tlast, tkeep, tdata}
   logic [72:0] exp_q[$];
   logic [72:0] cur_beat, prev_beat, exp_beat;
   logic [63:0] keep_mask;
   logic        stalled = 1'b0;
   logic        last_acc = 1'b0;
   int          wrr_cycles = 0;

   task automatic push_exp(input logic last, input logic [7:0] keep, input logic [63:0] data);
      exp_q.push_back({last, keep, data});
   endtask

   always @(negedge user_clk) begin
      cur_beat = {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata};
      if (!user_reset_n) begin
         stalled  = 1'b0;
         last_acc = 1'b0;
      end else begin
         if (last_acc) check("ready_after_tlast", 64'(cmd_ready), 64'd1);
         last_acc = 1'b0;
         if (stalled && s_axis_tx_tvalid) begin
            check("stable_data", cur_beat[63:0], prev_beat[63:0]);
            check("stable_ctl", 64'(cur_beat[72:64]), 64'(prev_beat[72:64]));
         end
         if (wr_ready) wrr_cycles++;
         if (s_axis_tx_tvalid && s_axis_tx_tready) begin
            check("req_held", 64'(s_axis_tx_req), 64'd1);
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               exp_beat = exp_q.pop_front();
               for (int i = 0; i < 8; i++) keep_mask[i*8 +: 8] = {8{exp_beat[64+i]}};
               check("beat_data", s_axis_tx_tdata & keep_mask, exp_beat[63:0] & keep_mask);
               check("beat_keep", 64'(s_axis_tx_tkeep), 64'(exp_beat[71:64]));
               check("beat_last", 64'(s_axis_tx_tlast), 64'(exp_beat[72]));
            end
            if (s_axis_tx_tlast) last_acc = 1'b1;
         end
         stalled   = s_axis_tx_tvalid && !s_axis_tx_tready;
         prev_beat = cur_beat;
      end
   end

   // payload driver
   logic [63:0] wr_q[$];
   int          wr_cnt = 0;
   logic        wr_acc;

   initial begin
      wr_valid = 1'b0;
      wr_data  = '0;
      forever begin
         @(negedge user_clk);
         wr_acc = wr_valid && wr_ready;
         @(posedge user_clk);
         #1;
         if (wr_acc && wr_q.size() > 0) begin
            void'(wr_q.pop_front());
            wr_cnt++;
         end
         if (wr_q.size() > 0) begin
            wr_valid = 1'b1;
            wr_data  = wr_q[0];
         end else begin
            wr_valid = 1'b0;
            wr_data  = '0;
         end
      end
   end

   // tready driver: steady or toggling
   logic tog_mode = 1'b0;
   initial begin
      s_axis_tx_tready = 1'b1;
      forever begin
         @(posedge user_clk);
         #1;
         s_axis_tx_tready = tog_mode ? ~s_axis_tx_tready : 1'b1;
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge user_clk);
      #1;
   endtask

   task automatic send_cmd(input logic wr, input logic [63:0] addr, input logic [9:0] len,
                           input logic [7:0] tag, input logic [3:0] fbe, input logic [3:0] lbe);
      int c = 0;
      while (!cmd_ready && c < 1000) begin
         tick(1);
         c++;
      end
      check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid    = 1'b1;
      cmd_is_write = wr;
      cmd_addr     = addr;
      cmd_len_dw   = len;
      cmd_tag      = tag;
      cmd_first_be = fbe;
      cmd_last_be  = lbe;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int c = 0;
      while (exp_q.size() != 0 && c < 3000) begin
         @(posedge user_clk);
         c++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
      tick(3);
   endtask

   int req_seen;

   initial begin
      user_reset_n        = 1'b0;
      cfg_bus_number      = 8'h01;
      cfg_device_number   = 5'h00;
      cfg_function_number = 3'h0;
      cmd_valid           = 1'b0;
      cmd_is_write        = 1'b0;
      cmd_addr            = '0;
      cmd_len_dw          = '0;
      cmd_tag             = '0;
      cmd_first_be        = '0;
      cmd_last_be         = '0;
      s_axis_tx_ack       = 1'b1;

      tick(3);
      check("rst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
      check("rst_req", 64'(s_axis_tx_req), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_cmd_err", 64'(cmd_err), 64'd0);
      check("rst_tdata", s_axis_tx_tdata, 64'd0);
      check("rst_tkeep_last_user", 64'({s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tuser}), 64'd0);
      user_reset_n = 1'b1;
      tick(1);
      check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

      // MWr32 len 3
      wr_cnt = 0;
      wr_q.push_back(64'hA1A1A1A1_A0A0A0A0);
      wr_q.push_back(64'h00000000_A2A2A2A2);
      push_exp(1'b0, 8'hFF, 64'h010005FF_40000003);
      push_exp(1'b0, 8'hFF, 64'hA0A0A0A0_00001000);
      push_exp(1'b1, 8'hFF, 64'hA2A2A2A2_A1A1A1A1);
      send_cmd(1'b1, 64'h1000, 10'd3, 8'h05, 4'hF, 4'hF);
      drain("mwr32_len3_drain");
      check("mwr32_len3_wr_beats", 64'(wr_cnt), 64'd2);

      // MWr32 len 2: held DW ends the packet without a further wr beat
      wr_cnt = 0;
      wr_q.push_back(64'hB1B1B1B1_B0B0B0B0);
      push_exp(1'b0, 8'hFF, 64'h0100063F_40000002);
      push_exp(1'b0, 8'hFF, 64'hB0B0B0B0_00002000);
      push_exp(1'b1, 8'h0F, 64'h00000000_B1B1B1B1);
      send_cmd(1'b1, 64'h2000, 10'd2, 8'h06, 4'hF, 4'h3);
      drain("mwr32_len2_drain");
      check("mwr32_len2_wr_beats", 64'(wr_cnt), 64'd1);

      // MWr64 len 2
      wr_cnt = 0;
      wr_q.push_back(64'hC1C1C1C1_C0C0C0C0);
      push_exp(1'b0, 8'hFF, 64'h010007FF_60000002);
      push_exp(1'b0, 8'hFF, 64'h00000040_00000001);
      push_exp(1'b1, 8'hFF, 64'hC1C1C1C1_C0C0C0C0);
      send_cmd(1'b1, 64'h1_0000_0040, 10'd2, 8'h07, 4'hF, 4'hF);
      drain("mwr64_len2_drain");
      check("mwr64_len2_wr_beats", 64'(wr_cnt), 64'd1);

      // MRd32 len 0 (1024 DW)
      wrr_cycles = 0;
      push_exp(1'b0, 8'hFF, 64'h010008FF_00000000);
      push_exp(1'b1, 8'h0F, 64'h00000000_00003004);
      send_cmd(1'b0, 64'h3004, 10'd0, 8'h08, 4'hF, 4'hF);
      drain("mrd32_len1024_drain");
      check("mrd32_no_wr_ready", 64'(wrr_cycles), 64'd0);

      // oversize write is dropped
      send_cmd(1'b1, 64'h6000, 10'd200, 8'h0E, 4'hF, 4'hF);
      check("drop_cmd_err_pulse", 64'(cmd_err), 64'd1);
      tick(1);
      check("drop_cmd_err_end", 64'(cmd_err), 64'd0);
      req_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (s_axis_tx_req || s_axis_tx_tvalid) req_seen++;
         tick(1);
      end
      check("drop_no_req", 64'(req_seen), 64'd0);
      check("drop_stays_idle", 64'(cmd_ready), 64'd1);

      // MRd64 len 1, other requester ID, last_be forced to 0
      cfg_bus_number      = 8'h12;
      cfg_device_number   = 5'h1F;
      cfg_function_number = 3'h5;
      push_exp(1'b0, 8'hFF, 64'h12FD090F_20000001);
      push_exp(1'b1, 8'hFF, 64'h00000010_00000002);
      send_cmd(1'b0, 64'h2_0000_0010, 10'd1, 8'h09, 4'hF, 4'hF);
      drain("mrd64_len1_drain");
      cfg_bus_number      = 8'h01;
      cfg_device_number   = 5'h00;
      cfg_function_number = 3'h0;

      // MWr32 len 5 with toggling tready and a payload gap
      tog_mode = 1'b1;
      wr_cnt   = 0;
      wr_q.push_back(64'hE1E1E1E1_E0E0E0E0);
      push_exp(1'b0, 8'hFF, 64'h01000A1F_40000005);
      push_exp(1'b0, 8'hFF, 64'hE0E0E0E0_00004008);
      push_exp(1'b0, 8'hFF, 64'hE2E2E2E2_E1E1E1E1);
      push_exp(1'b1, 8'hFF, 64'hE4E4E4E4_E3E3E3E3);
      send_cmd(1'b1, 64'h4008, 10'd5, 8'h0A, 4'hF, 4'h1);
      tick(8);
      wr_q.push_back(64'hE3E3E3E3_E2E2E2E2);
      wr_q.push_back(64'h00000000_E4E4E4E4);
      drain("mwr32_len5_tog_drain");
      check("mwr32_len5_wr_beats", 64'(wr_cnt), 64'd3);

      // MWr64 len 3 with toggling tready, odd final count
      wr_cnt = 0;
      wr_q.push_back(64'hF1F1F1F1_F0F0F0F0);
      wr_q.push_back(64'h00000000_F2F2F2F2);
      push_exp(1'b0, 8'hFF, 64'h01000BFF_60000003);
      push_exp(1'b0, 8'hFF, 64'h00000100_00000005);
      push_exp(1'b0, 8'hFF, 64'hF1F1F1F1_F0F0F0F0);
      push_exp(1'b1, 8'h0F, 64'h00000000_F2F2F2F2);
      send_cmd(1'b1, 64'h5_0000_0100, 10'd3, 8'h0B, 4'hF, 4'hF);
      drain("mwr64_len3_tog_drain");
      check("mwr64_len3_wr_beats", 64'(wr_cnt), 64'd2);
      tog_mode = 1'b0;
      tick(2);

`ifdef TLP_TX_STATS_EN
      check("stat_tlp_cnt", 64'(stat_tlp_cnt), 64'd7);
      check("stat_dw_cnt", 64'(stat_dw_cnt), 64'd15);
`endif

      // reset in the middle of a packet
      push_exp(1'b0, 8'hFF, 64'h01000DFF_40000003);
      send_cmd(1'b1, 64'h7000, 10'd3, 8'h0D, 4'hF, 4'hF);
      tick(6);
      check("partial_hdr0_sent", 64'(exp_q.size()), 64'd0);
      check("partial_waits_payload", 64'(wr_ready), 64'd1);
      user_reset_n = 1'b0;
      #1;
      check("midrst_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
      check("midrst_req", 64'(s_axis_tx_req), 64'd0);
      check("midrst_wr_ready", 64'(wr_ready), 64'd0);
      check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
      exp_q.delete();
      wr_q.delete();
      tick(2);
      user_reset_n = 1'b1;
      tick(2);

      // grant withheld: request stays up, nothing is sent
      s_axis_tx_ack = 1'b0;
      push_exp(1'b0, 8'hFF, 64'h01000C0F_00000001);
      push_exp(1'b1, 8'h0F, 64'h00000000_00000010);
      send_cmd(1'b0, 64'h10, 10'd1, 8'h0C, 4'hF, 4'hF);
      tick(5);
      check("noack_req", 64'(s_axis_tx_req), 64'd1);
      check("noack_tvalid", 64'(s_axis_tx_tvalid), 64'd0);
      s_axis_tx_ack = 1'b1;
      drain("after_ack_drain");
      check("req_released", 64'(s_axis_tx_req), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
